// File: rtl/axi2ahb_rd_ctrl_if.sv
// Bus bundle between the AHB read-burst sequencer and its environment:
// AXI read command handshake, AHB address/control signals and read-data FIFO tagging.
interface axi2ahb_rd_ctrl_if #(
  parameter int ADDR_BITS = 32,
  parameter int ID_BITS   = 4
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [3:0]           cmd_len;
  logic [1:0]           cmd_size;
  logic [ID_BITS-1:0]   cmd_id_in;
  logic                 cmd_err_in;

  logic [ADDR_BITS-1:0] HADDR;
  logic [1:0]           HTRANS;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic                 HWRITE;
  logic                 HREADY;

  logic                 rdata_phase;
  logic                 data_last;
  logic [ID_BITS-1:0]   cmd_id;
  logic                 cmd_err;
  logic                 rdata_ready;

  // The sequencer is the AHB master; the environment (command queue, AHB slave, FIFO) is the slave side.
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_id_in, cmd_err_in, HREADY, rdata_ready,
    output cmd_ready, HADDR, HTRANS, HSIZE, HBURST, HWRITE, rdata_phase, data_last, cmd_id, cmd_err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_id_in, cmd_err_in, HREADY, rdata_ready,
    input  cmd_ready, HADDR, HTRANS, HSIZE, HBURST, HWRITE, rdata_phase, data_last, cmd_id, cmd_err
  );
endinterface

// File: rtl/axi2ahb_rd_ctrl.sv
// AHB read-burst sequencer: turns AXI read commands into INCR address phases and tags
// the resulting data phases for the read data FIFO; errored commands complete locally.
module axi2ahb_rd_ctrl #(
  parameter int ADDR_BITS = 32,
  parameter int ID_BITS   = 4
) (
  input logic              clk,
  input logic              reset,
  axi2ahb_rd_ctrl_if.master bus
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {IDLE, ADDR, ERR} state_t;

  state_t               state;
  logic [3:0]           beat_cnt;
  logic [3:0]           len_q;
  logic [ID_BITS-1:0]   id_q;
  logic                 last_beat;
  logic                 addr_done;
  logic                 accept;
  logic                 err_go;
  logic [ADDR_BITS-1:0] next_addr;

  assign last_beat = (beat_cnt == len_q);
  assign addr_done = (state == ADDR) && (bus.HTRANS != TR_IDLE) && bus.HREADY;
  assign bus.cmd_ready = bus.rdata_ready &&
                         ((state == IDLE) || ((state == ADDR) && last_beat && bus.HREADY));
  assign accept    = bus.cmd_valid && bus.cmd_ready;
  // A local error beat must not overwrite an AHB data phase still stretched by wait states.
  assign err_go    = !(bus.rdata_phase && !bus.cmd_err && !bus.HREADY);
  assign next_addr = bus.HADDR + (ADDR_BITS'(1) << bus.HSIZE[1:0]);

  assign bus.HBURST = 3'b001;
  assign bus.HWRITE = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      beat_cnt        <= 4'd0;
      len_q           <= 4'd0;
      id_q            <= '0;
      bus.HADDR       <= '0;
      bus.HTRANS      <= TR_IDLE;
      bus.HSIZE       <= 3'b000;
      bus.rdata_phase <= 1'b0;
      bus.data_last   <= 1'b0;
      bus.cmd_id      <= '0;
      bus.cmd_err     <= 1'b0;
    end else begin
      // Data-phase pipeline register: loaded by a completed address phase or an error beat.
      if (addr_done) begin
        bus.rdata_phase <= 1'b1;
        bus.data_last   <= last_beat;
        bus.cmd_id      <= id_q;
        bus.cmd_err     <= 1'b0;
      end else if ((state == ERR) && err_go) begin
        bus.rdata_phase <= 1'b1;
        bus.data_last   <= last_beat;
        bus.cmd_id      <= id_q;
        bus.cmd_err     <= 1'b1;
      end else if (bus.rdata_phase && (bus.cmd_err || bus.HREADY)) begin
        bus.rdata_phase <= 1'b0;
        bus.data_last   <= 1'b0;
      end

      if (accept) begin
        len_q    <= bus.cmd_len;
        id_q     <= bus.cmd_id_in;
        beat_cnt <= 4'd0;
        if (bus.cmd_err_in) begin
          state      <= ERR;
          bus.HTRANS <= TR_IDLE;
        end else begin
          state      <= ADDR;
          bus.HTRANS <= TR_NONSEQ;
          bus.HADDR  <= bus.cmd_addr;
          bus.HSIZE  <= {1'b0, bus.cmd_size};
        end
      end else begin
        case (state)
          ADDR: begin
            if (bus.HREADY) begin
              if (last_beat) begin
                state      <= IDLE;
                bus.HTRANS <= TR_IDLE;
              end else begin
                beat_cnt   <= beat_cnt + 4'd1;
                bus.HADDR  <= next_addr;
                // Crossing a 1KB boundary restarts the burst with NONSEQ.
                bus.HTRANS <= (next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
              end
            end
          end
          ERR: begin
            if (err_go) begin
              if (last_beat) state <= IDLE;
              else beat_cnt <= beat_cnt + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
